// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index
// width, the hard-wired zero register and the memory wait-state FSM encoding.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts one per cycle while inc is high and holds
// at all-ones. clear is a synchronous zero; rst is asynchronous, active-low.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count register; stops at all-ones so the value never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Drives PC / pipeline-register enables and flushes from the load-use,
// memory-wait and branch-redirect conditions, keeps a memory wait-state FSM
// with timeout, and counts each stall/redirect class in saturating counters.
// Build option HAZARD_FWD_EN: forwarding unit present, so only a load in EX
// feeding the ID instruction stalls; otherwise any in-flight writer in EX or
// MEM whose result the ID instruction reads stalls it.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_rs1_used,
  input  logic             ifid_rs2_used,
  input  logic [4:0]       idex_rd,
  input  logic             idex_reg_write,
  input  logic             idex_mem_read,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_reg_write,
  input  logic             exmem_mem_req,
  input  logic             mem_ready,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             hazard_error,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT) + 1;

  state_t           r_state, w_state_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic             w_ex_hit;
  logic             w_data_hazard;
  logic             w_mem_stall;
  logic             w_inc_lu, w_inc_rd, w_inc_wt;
  logic             w_unused;

  // A source matches a producer only if it is really read and the producer
  // really writes a non-zero register (x0 never creates a dependency)
  function automatic logic f_match(input logic [REG_W-1:0] rs, input logic used,
                                   input logic [REG_W-1:0] rd, input logic wr);
    return used && wr && (rs == rd) && (rd != REG_ZERO);
  endfunction

  assign w_ex_hit = f_match(ifid_rs1, ifid_rs1_used, idex_rd, idex_reg_write) ||
                    f_match(ifid_rs2, ifid_rs2_used, idex_rd, idex_reg_write);

`ifdef HAZARD_FWD_EN
  // ALU results are forwarded; only a load's data arrives too late for EX
  assign w_data_hazard = idex_mem_read && w_ex_hit;
  // MEM-stage writer is covered by forwarding, so its fields are not needed
  assign w_unused      = ^{exmem_rd, exmem_reg_write};
`else
  logic w_mem_hit;
  assign w_mem_hit     = f_match(ifid_rs1, ifid_rs1_used, exmem_rd, exmem_reg_write) ||
                         f_match(ifid_rs2, ifid_rs2_used, exmem_rd, exmem_reg_write);
  // Without forwarding the consumer waits until the producer reaches WB
  assign w_data_hazard = w_ex_hit || w_mem_hit;
  // Load/ALU distinction is irrelevant when every writer stalls
  assign w_unused      = idex_mem_read;
`endif

  assign w_mem_stall  = exmem_mem_req && !mem_ready;
  assign hazard_error = (r_state == ERROR);

  // Prioritised enable/flush decode; also flags which class each cycle counts as
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    w_inc_lu    = 1'b0;
    w_inc_rd    = 1'b0;
    w_inc_wt    = 1'b0;
    if (!rst) begin
      // Hold everything and fill the pipe with bubbles while in reset
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (r_state == ERROR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (w_mem_stall) begin
      // Freeze everything up to MEM (a branch in EX stays put); bubble into WB
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      w_inc_wt    = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash the two wrong-path instructions behind the redirect
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      w_inc_rd   = 1'b1;
    end else if (w_data_hazard) begin
      // Hold PC and ID, insert one bubble into EX
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      w_inc_lu   = 1'b1;
    end
  end

  // Memory wait-state next-state and timeout timer
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = WAIT;
          w_timer_nxt = TMR_W'(1);
        end
      end
      WAIT: begin
        if (!w_mem_stall) begin
          w_state_nxt = RUN;
          w_timer_nxt = '0;
        end else if (r_timer == TMR_W'(MEM_TIMEOUT - 1)) begin
          w_state_nxt = ERROR;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ERROR: begin
        w_state_nxt = ERROR;
      end
      default: begin
        w_state_nxt = RUN;
        w_timer_nxt = '0;
      end
    endcase
  end

  // FSM state and timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc_lu),
    .clear (1'b0),
    .count (load_use_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc_rd),
    .clear (1'b0),
    .count (redirect_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc_wt),
    .clear (1'b0),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus
// randomized traffic, all compared against a behavioural model that works from
// the hazard rules directly (producer lists, consecutive-stall run length,
// integer saturating counts).
module tb_hazard_control_unit;

  localparam int MT   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    ifid_rs1, ifid_rs2, idex_rd, exmem_rd;
  logic          ifid_rs1_used, ifid_rs2_used;
  logic          idex_reg_write, idex_mem_read, exmem_reg_write;
  logic          exmem_mem_req, mem_ready, ex_branch_taken;
  logic          pc_en, ifid_en, idex_en, exmem_en;
  logic          ifid_flush, idex_flush, memwb_flush, hazard_error;
  logic [CW-1:0] load_use_cnt, redirect_cnt, wait_cnt;

  hazard_control_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_rs1_used   (ifid_rs1_used),
    .ifid_rs2_used   (ifid_rs2_used),
    .idex_rd         (idex_rd),
    .idex_reg_write  (idex_reg_write),
    .idex_mem_read   (idex_mem_read),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_mem_req   (exmem_mem_req),
    .mem_ready       (mem_ready),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .hazard_error    (hazard_error),
    .load_use_cnt    (load_use_cnt),
    .redirect_cnt    (redirect_cnt),
    .wait_cnt        (wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model state
  bit m_err;
  int m_run;
  int m_lu, m_rd, m_wt;

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Does the ID instruction read a register some in-flight producer will write?
  function automatic bit m_hazard();
    bit          hit;
    logic [4:0]  rs;
    bit          used;
    hit = 0;
    for (int i = 0; i < 2; i++) begin
      rs   = (i == 0) ? ifid_rs1 : ifid_rs2;
      used = (i == 0) ? ifid_rs1_used : ifid_rs2_used;
      if (used && rs != 5'd0) begin
`ifdef HAZARD_FWD_EN
        if (idex_reg_write && idex_mem_read && rs == idex_rd) hit = 1;
`else
        if (idex_reg_write && rs == idex_rd) hit = 1;
        if (exmem_reg_write && rs == exmem_rd) hit = 1;
`endif
      end
    end
    return hit;
  endfunction

  // 0 reset, 1 error, 2 memory wait, 3 redirect, 4 data hazard, 5 run
  function automatic int m_class();
    if (!rst) return 0;
    if (m_err) return 1;
    if (exmem_mem_req && !mem_ready) return 2;
    if (ex_branch_taken) return 3;
    if (m_hazard()) return 4;
    return 5;
  endfunction

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
  function automatic logic [6:0] m_ctl(input int c);
    case (c)
      0:       return 7'b0000_111;
      1:       return 7'b0000_000;
      2:       return 7'b0000_001;
      3:       return 7'b1111_110;
      4:       return 7'b0011_010;
      default: return 7'b1111_000;
    endcase
  endfunction

  // Compare this cycle's outputs with the model, then advance the model
  task automatic check();
    int c;
    #1;
    if (!rst) begin
      m_err = 0; m_run = 0; m_lu = 0; m_rd = 0; m_wt = 0;
    end
    c = m_class();
    chk("ctl", {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}, m_ctl(c));
    chk("hazard_error", hazard_error, m_err);
    chk("load_use_cnt", load_use_cnt, m_lu);
    chk("redirect_cnt", redirect_cnt, m_rd);
    chk("wait_cnt", wait_cnt, m_wt);
    if (c == 2) begin
      m_wt = sat_inc(m_wt);
      m_run++;
      if (m_run == MT) m_err = 1;
    end else if (c != 1) begin
      m_run = 0;
    end
    if (c == 3) m_rd = sat_inc(m_rd);
    if (c == 4) m_lu = sat_inc(m_lu);
  endtask

  task automatic idle();
    rst = 1'b1;
    ifid_rs1 = 5'd1; ifid_rs2 = 5'd2; ifid_rs1_used = 1'b0; ifid_rs2_used = 1'b0;
    idex_rd = 5'd0; idex_reg_write = 1'b0; idex_mem_read = 1'b0;
    exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_mem_req = 1'b0;
    mem_ready = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); rst = 1'b0; check();
    end
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_memwb_flush", memwb_flush, 1'b1);
  endtask

  task automatic load_use_cycle();
    @(negedge clk); idle();
    idex_rd = 5'd5; idex_reg_write = 1'b1; idex_mem_read = 1'b1;
    ifid_rs1 = 5'd5; ifid_rs1_used = 1'b1;
    check();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    m_err = 0; m_run = 0; m_lu = 0; m_rd = 0; m_wt = 0;
    do_reset();
    chk("rst_cnt", load_use_cnt, 0);

    // Load x5 in EX feeding rs1: exactly one bubble
    load_use_cycle();
    chk("lu_pc_en", pc_en, 1'b0);
    chk("lu_idex_flush", idex_flush, 1'b1);
    @(negedge clk); idle(); check();
    chk("lu_cnt", load_use_cnt, 1);
    chk("lu_released", pc_en, 1'b1);

    // ALU result x7 in MEM read by rs2
    @(negedge clk); idle();
    exmem_rd = 5'd7; exmem_reg_write = 1'b1; ifid_rs2 = 5'd7; ifid_rs2_used = 1'b1;
    check();
`ifdef HAZARD_FWD_EN
    chk("mem_prod_pc_en", pc_en, 1'b1);
`else
    chk("mem_prod_pc_en", pc_en, 1'b0);
`endif

    // x0 producers never stall
    @(negedge clk); idle();
    idex_rd = 5'd0; idex_reg_write = 1'b1; idex_mem_read = 1'b1;
    exmem_rd = 5'd0; exmem_reg_write = 1'b1;
    ifid_rs1 = 5'd0; ifid_rs1_used = 1'b1; ifid_rs2 = 5'd0; ifid_rs2_used = 1'b1;
    check();
    chk("x0_pc_en", pc_en, 1'b1);

    // Ready in the request cycle: no stall
    @(negedge clk); idle(); exmem_mem_req = 1'b1; mem_ready = 1'b1; check();
    chk("ready_now_exmem_en", exmem_en, 1'b1);

    // Branch held in EX across a 3-cycle memory wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); exmem_mem_req = 1'b1; ex_branch_taken = 1'b1; check();
      chk("brwait_memwb_flush", memwb_flush, 1'b1);
      chk("brwait_ifid_flush", ifid_flush, 1'b0);
    end
    @(negedge clk); idle(); exmem_mem_req = 1'b1; mem_ready = 1'b1; ex_branch_taken = 1'b1; check();
    chk("br_after_ifid_flush", ifid_flush, 1'b1);
    chk("br_after_idex_flush", idex_flush, 1'b1);
    @(negedge clk); idle(); check();
    chk("br_wait_cnt", wait_cnt, 3);
    chk("br_redirect_cnt", redirect_cnt, 1);

    // Branch and load-use together: redirect wins, no load-use count
    @(negedge clk); idle();
    idex_rd = 5'd9; idex_reg_write = 1'b1; idex_mem_read = 1'b1;
    ifid_rs2 = 5'd9; ifid_rs2_used = 1'b1; ex_branch_taken = 1'b1;
    check();
    chk("br_vs_lu_pc_en", pc_en, 1'b1);
    @(negedge clk); idle(); check();
    chk("br_vs_lu_cnt", load_use_cnt, 0);

    // Memory never ready: error after MT stalled cycles, cleared by reset
    do_reset();
    for (int i = 0; i < MT + 2; i++) begin
      @(negedge clk); idle(); exmem_mem_req = 1'b1; check();
    end
    chk("timeout_error", hazard_error, 1'b1);
    chk("timeout_pc_en", pc_en, 1'b0);
    chk("timeout_memwb_flush", memwb_flush, 1'b0);
    do_reset();
    @(negedge clk); idle(); check();
    chk("timeout_cleared", hazard_error, 1'b0);

    // Saturation of the load-use counter
    do_reset();
    for (int i = 0; i < CMAX + 6; i++) load_use_cycle();
    @(negedge clk); idle(); check();
    chk("lu_saturated", load_use_cnt, CMAX);

    // Randomized traffic with occasional reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); idle();
      rst             = ($urandom_range(0, 63) != 0);
      ifid_rs1        = 5'($urandom_range(0, 3));
      ifid_rs2        = 5'($urandom_range(0, 3));
      ifid_rs1_used   = 1'($urandom_range(0, 1));
      ifid_rs2_used   = 1'($urandom_range(0, 1));
      idex_rd         = 5'($urandom_range(0, 3));
      idex_reg_write  = 1'($urandom_range(0, 1));
      idex_mem_read   = 1'($urandom_range(0, 1));
      exmem_rd        = 5'($urandom_range(0, 3));
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_mem_req   = 1'($urandom_range(0, 1));
      mem_ready       = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      check();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
